// File: rtl/nios_system_nios2_qsys_1_oci_dct_packer_if.sv
// Bundle of every non-clock signal of the DCT frame packer.
//   master : the packer itself. It takes code_valid/code, flush, trace_stop and
//            frame_ready in, and drives code_ready, the frame (dct_buffer,
//            dct_count, frame_valid), the end-of-test flags and state_dbg.
//   slave  : the environment. It drives the trace codes and control pulses and
//            consumes the frames.
// Handshake rule, used for both the code side and the frame side: a transfer
// happens on a rising clk edge where valid && ready are both high. Once valid
// is raised, the payload holds until that transfer. ready may be computed
// without looking at valid.
interface nios_system_nios2_qsys_1_oci_dct_packer_if;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        trace_stop;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic        frame_ready;
  logic        test_ending;
  logic        test_has_ended;
  logic [1:0]  state_dbg;   // 0 = RUN, 1 = ENDING, 2 = ENDED

  modport master (
    input  code_valid, code, flush, trace_stop, frame_ready,
    output code_ready, dct_buffer, dct_count, frame_valid,
           test_ending, test_has_ended, state_dbg
  );

  modport slave (
    output code_valid, code, flush, trace_stop, frame_ready,
    input  code_ready, dct_buffer, dct_count, frame_valid,
           test_ending, test_has_ended, state_dbg
  );
endinterface

// File: rtl/nios_system_nios2_qsys_1_oci_dct_packer.sv
// Producer side of the OCI compressed-trace frame interface.
// Trace codes arrive one per cycle and are shifted into a 15-slot accumulator.
// The newest code sits at [1:0]. A frame is emitted in any of these cases:
//   - the accumulator fills,
//   - a flush is requested,
//   - the trace session is ending.
// On trace_stop the partial frame is drained, then test_has_ended is raised.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : master side of nios_system_nios2_qsys_1_oci_dct_packer_if
module nios_system_nios2_qsys_1_oci_dct_packer (
  input logic clk,
  input logic reset,
  nios_system_nios2_qsys_1_oci_dct_packer_if.master bus
);
  localparam int CODE_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = CODE_W * SLOTS;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {RUN = 2'd0, ENDING = 2'd1, ENDED = 2'd2} state_t;

  state_t           state, state_next;
  logic [BUF_W-1:0] acc, next_acc;
  logic [CNT_W-1:0] acc_cnt, next_cnt;
  logic             flush_pend;
  logic             accept, out_free, flush_eff, load;

  assign bus.code_ready = (state == RUN) && (acc_cnt != CNT_W'(SLOTS));
  assign bus.state_dbg  = state;

  always_comb begin
    accept    = bus.code_valid && bus.code_ready;
    next_acc  = accept ? {acc[BUF_W-CODE_W-1:0], bus.code} : acc;
    next_cnt  = acc_cnt + CNT_W'(accept);
    out_free  = !bus.frame_valid || bus.frame_ready;
    // Once the session has ended the accumulator is always empty, so a flush
    // there has nothing to emit.
    flush_eff = bus.flush && (state != ENDED);
    // A load never fires on an empty accumulator. Because of this, no
    // zero-count frame can ever be produced.
    load      = out_free && (next_cnt != '0) &&
                ((next_cnt == CNT_W'(SLOTS)) || flush_pend || flush_eff ||
                 (state == ENDING));

    state_next = state;
    case (state)
      RUN:     if (bus.trace_stop) state_next = ENDING;
      // Leave ENDING once nothing is buffered and the last frame has been
      // taken by the consumer.
      ENDING:  if ((acc_cnt == '0) && !bus.frame_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= RUN;
      acc                <= '0;
      acc_cnt            <= '0;
      flush_pend         <= 1'b0;
      bus.dct_buffer     <= '0;
      bus.dct_count      <= '0;
      bus.frame_valid    <= 1'b0;
      bus.test_ending    <= 1'b0;
      bus.test_has_ended <= 1'b0;
    end else begin
      state              <= state_next;
      bus.test_ending    <= (state_next == ENDING);
      bus.test_has_ended <= (state_next == ENDED);

      if (load) begin
        bus.dct_buffer  <= next_acc;
        bus.dct_count   <= next_cnt;
        bus.frame_valid <= 1'b1;
        acc             <= '0;
        acc_cnt         <= '0;
        flush_pend      <= 1'b0;
      end else begin
        acc     <= next_acc;
        acc_cnt <= next_cnt;
        if (bus.frame_valid && bus.frame_ready) bus.frame_valid <= 1'b0;
        // A flush that cannot load now, because the output is stalled, is
        // remembered until the output frees up.
        if (flush_eff && (next_cnt != '0)) flush_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nios_system_nios2_qsys_1_oci_dct_packer.sv
module tb_nios_system_nios2_qsys_1_oci_dct_packer;
  logic clk;
  logic reset;

  nios_system_nios2_qsys_1_oci_dct_packer_if bus ();

  nios_system_nios2_qsys_1_oci_dct_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];   // {dct_count, dct_buffer}

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- check + driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.code_valid  = 1'b0;
    bus.code        = 2'b00;
    bus.flush       = 1'b0;
    bus.trace_stop  = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus.frame_valid && bus.frame_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {bus.dct_count, bus.dct_buffer}, 34'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("frame", {bus.dct_count, bus.dct_buffer}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  s3_codes [3];
    logic [29:0] e4;
    logic [1:0]  c;
    int          k;

    s3_codes = '{2'b11, 2'b10, 2'b01};
    idle_inputs();
    bus.frame_ready = 1'b0;
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_dct_count", bus.dct_count, 0);
    check("rst_dct_buffer", bus.dct_buffer, 0);
    check("rst_test_ending", bus.test_ending, 0);
    check("rst_test_has_ended", bus.test_has_ended, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_code_ready", bus.code_ready, 1);

    // 1: fifteen 01 codes back to back; frame appears the cycle after the 15th
    step();
    bus.frame_ready = 1'b1;
    exp_q.push_back({4'd15, 30'h15555555});
    for (int i = 0; i < 15; i++) begin
      bus.code_valid = 1'b1;
      bus.code = 2'b01;
      @(negedge clk);
      check("s1_code_ready", bus.code_ready, 1);
      step();
    end
    idle_inputs();
    @(negedge clk);
    check("s1_latency", bus.frame_valid, 1);
    step();
    @(negedge clk);
    check("s1_single_frame", bus.frame_valid, 0);
    check("s1_drained", exp_q.size(), 0);

    // 2: output stalled across 30 codes, then released
    step();
    bus.frame_ready = 1'b0;
    exp_q.push_back({4'd15, 30'h2AAAAAAA});
    exp_q.push_back({4'd15, 30'h2AAAAAAA});
    for (int i = 0; i < 30; i++) begin
      bus.code_valid = 1'b1;
      bus.code = 2'b10;
      @(negedge clk);
      check("s2_code_ready", bus.code_ready, 1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s2_full_refuse", bus.code_ready, 0);
      check("s2_held_valid", bus.frame_valid, 1);
      check("s2_held_frame", {bus.dct_count, bus.dct_buffer}, {4'd15, 30'h2AAAAAAA});
      step();
    end
    idle_inputs();
    bus.frame_ready = 1'b1;
    step();
    @(negedge clk);
    check("s2_second_valid", bus.frame_valid, 1);
    check("s2_ready_back", bus.code_ready, 1);
    step();
    @(negedge clk);
    check("s2_idle", bus.frame_valid, 0);
    check("s2_drained", exp_q.size(), 0);

    // 3: partial frame via flush
    step();
    exp_q.push_back({4'd3, 30'h39});
    for (int i = 0; i < 3; i++) begin
      bus.code_valid = 1'b1;
      bus.code = s3_codes[i];
      step();
    end
    idle_inputs();
    bus.flush = 1'b1;
    @(negedge clk);
    check("s3_no_frame_yet", bus.frame_valid, 0);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("s3_flushed", bus.frame_valid, 1);
    step();
    @(negedge clk);
    check("s3_drained", exp_q.size(), 0);

    // 4: flush on empty accumulator, then flush alongside the 15th code
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s4_empty_flush", bus.frame_valid, 0);
      step();
    end
    e4 = '0;
    for (int i = 0; i < 15; i++) begin
      c = 2'($urandom_range(0, 3));
      e4 = {e4[27:0], c};
      bus.code_valid = 1'b1;
      bus.code = c;
      bus.flush = (i == 14);
      step();
    end
    exp_q.push_back({4'd15, e4});
    idle_inputs();
    @(negedge clk);
    check("s4_full_frame", bus.frame_valid, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s4_no_extra", bus.frame_valid, 0);
      step();
    end
    check("s4_drained", exp_q.size(), 0);

    // 5: end-of-test, stop in same cycle as 5th code
    exp_q.push_back({4'd5, 30'h3FF});
    for (int i = 0; i < 5; i++) begin
      bus.code_valid = 1'b1;
      bus.code = 2'b11;
      bus.trace_stop = (i == 4);
      step();
    end
    bus.trace_stop = 1'b0;   // code_valid stays high
    @(negedge clk);
    check("s5_test_ending", bus.test_ending, 1);
    check("s5_refuse", bus.code_ready, 0);
    k = 0;
    while (!bus.test_has_ended && k < 10) begin
      step();
      @(negedge clk);
      check("s5_refuse_drain", bus.code_ready, 0);
      k++;
    end
    check("s5_has_ended", bus.test_has_ended, 1);
    check("s5_ending_clear", bus.test_ending, 0);
    check("s5_drained", exp_q.size(), 0);
    step();
    bus.trace_stop = 1'b1;
    bus.flush = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s5_sticky", bus.test_has_ended, 1);
      check("s5_no_frame", bus.frame_valid, 0);
      check("s5_ended_refuse", bus.code_ready, 0);
      step();
    end

    // 6: reset mid-frame with a stalled frame and 7 buffered codes
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.frame_ready = 1'b0;
    step();
    for (int i = 0; i < 22; i++) begin
      bus.code_valid = 1'b1;
      bus.code = 2'b01;
      step();
    end
    idle_inputs();
    @(negedge clk);
    check("s6_stalled", bus.frame_valid, 1);
    step();
    reset = 1'b1;
    #2;
    check("s6_async_valid", bus.frame_valid, 0);
    check("s6_async_count", bus.dct_count, 0);
    check("s6_async_buffer", bus.dct_buffer, 0);
    check("s6_async_ending", bus.test_ending, 0);
    step();
    reset = 1'b0;
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s6_no_residual", bus.frame_valid, 0);
      check("s6_code_ready", bus.code_ready, 1);
      step();
    end
    exp_q.push_back({4'd15, 30'h15555555});
    for (int i = 0; i < 15; i++) begin
      bus.code_valid = 1'b1;
      bus.code = 2'b01;
      step();
    end
    idle_inputs();
    @(negedge clk);
    check("s6_clean_frame", bus.frame_valid, 1);
    step();
    step();

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
